key_router: RTL and testbench
=============================

KEY_ROUTER -- requirements
Module: key_router

Interface
REQ-001 SHALL have parameter SWAP_LEN, 5, swap-window length in seconds (1..15).
REQ-002 SHALL have parameter BOOM_COOL, 10, boom cooldown in seconds (0..15).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 key_event  input  11  PS/2 event: [10] valid, [9] extended, [8] break, [7:0] scan code.
REQ-006 start  input  1  game running; high enables movement, boom and swap timing.
REQ-007 sec_tick  input  1  one-cycle pulse per game-timer second.
REQ-008 swap_req  input  1  one-cycle pulse requesting a control-swap window.
REQ-009 p1_up, p1_down, p1_left, p1_right  output  1 each  player-1 movement pulses.
REQ-010 p2_up, p2_down, p2_left, p2_right  output  1 each  player-2 movement pulses.
REQ-011 boom1_p, boom2_p  output  1 each  granted boom pulse, per player.
REQ-012 space_p, pause_p, reset_p  output  1 each  system-key pulses.
REQ-013 swapped  output  1  high while swap window active.
REQ-014 swap_left  output  4  seconds remaining in swap window.

Function
REQ-015 last_code register SHALL load key_event[7:0] every cycle.
REQ-016 Accept condition SHALL be key_event[10] & ~key_event[8] & (key_event[7:0] != last_code).
REQ-017 All pulse outputs SHALL be registered, high exactly one cycle, asserted the edge after the accepting sample; low otherwise.
REQ-018 Pad-1 codes: 1D up, 1C left, 1B down, 23 right, 16 boom; extension bit ignored.
REQ-019 Pad-2 codes: 75 up, 6B left, 72 down, 74 right, valid only with key_event[9]=1; 69 boom, extension ignored.
REQ-020 System codes: 29 -> space_p, 4D -> pause_p, 2D -> reset_p; emitted regardless of start or swap state.
REQ-021 Unlisted codes, and arrow codes with key_event[9]=0, SHALL produce no output.
REQ-022 Routing: swapped=0 -> pad-1 to player 1, pad-2 to player 2; swapped=1 -> crossed; boom keys follow the same routing.
REQ-023 Routing SHALL use the swapped value registered at the accepting edge.
REQ-024 Movement and boom pulses SHALL be suppressed when start=0 at the accepting sample.
REQ-025 Swap FSM states NORMAL, SWAPPED; swapped = (state==SWAPPED).
REQ-026 NORMAL: swap_req & start -> SWAPPED, swap_left <= SWAP_LEN.
REQ-027 SWAPPED: swap_req & start -> reload swap_left <= SWAP_LEN, stay SWAPPED.
REQ-028 SWAPPED: sec_tick & start & ~swap_req -> swap_left-1; from 1, go NORMAL with swap_left=0.
REQ-029 swap_req and sec_tick in same cycle: reload wins, no decrement.
REQ-030 start=0 SHALL freeze FSM, swap_left and cooldowns.
REQ-031 Per-player cooldown cool1, cool2 (4 bits); boom request for player N granted only if coolN==0, then coolN <= BOOM_COOL.
REQ-032 Denied boom request SHALL be dropped, not queued.
REQ-033 coolN SHALL decrement on sec_tick & start while nonzero; saturates at 0.
REQ-034 Grant and sec_tick in same cycle: cooldown loads BOOM_COOL (load wins).
REQ-035 Accepted reset key SHALL, at the same edge reset_p asserts, force NORMAL, swap_left=0, cool1=cool2=0.

Reset
REQ-036 rstn low SHALL immediately clear all outputs to 0, last_code to 8'h00, FSM to NORMAL, cool1=cool2=0.
REQ-037 Reset mid-window or mid-cooldown SHALL discard state; no pulse in the first cycle after release.

Verification
REQ-038 start=1, NORMAL; event valid code 1D, held 3 cycles -> p1_up one cycle at edge after first sample, no repeat.
REQ-039 swap_req with start=1, then code 1C -> p2_left; 5 sec_ticks -> swap_left 5,4,3,2,1,0, swapped falls with fifth tick.
REQ-040 swap_left=2, swap_req and sec_tick same cycle -> swap_left=5, swapped stays 1.
REQ-041 start=1, code 16 -> boom1_p, cool1=10; code 16 again (via 00 in between) before 10 ticks -> no pulse; after 10 ticks -> boom1_p.
REQ-042 code 75 with key_event[9]=0 -> no output; start=0 code 23 -> no output; code 29 with start=0 -> space_p.
REQ-043 swapped=1, cool2=7, code 2D -> reset_p, swapped=0, swap_left=0, cool2=0 next cycle; rstn pulse mid-window -> all 0 asynchronously.

Source files
------------

// File: rtl/key_router_if.sv
// Bundles the keyboard event, game-timing inputs and all routed pulse outputs
// of the key router into one port group.
interface key_router_if;
   logic [10:0] key_event;
   logic        start;
   logic        sec_tick;
   logic        swap_req;
   logic        p1_up;
   logic        p1_down;
   logic        p1_left;
   logic        p1_right;
   logic        p2_up;
   logic        p2_down;
   logic        p2_left;
   logic        p2_right;
   logic        boom1_p;
   logic        boom2_p;
   logic        space_p;
   logic        pause_p;
   logic        reset_p;
   logic        swapped;
   logic [3:0]  swap_left;

   modport master (
      output key_event, start, sec_tick, swap_req,
      input  p1_up, p1_down, p1_left, p1_right,
      input  p2_up, p2_down, p2_left, p2_right,
      input  boom1_p, boom2_p, space_p, pause_p, reset_p,
      input  swapped, swap_left
   );

   modport slave (
      input  key_event, start, sec_tick, swap_req,
      output p1_up, p1_down, p1_left, p1_right,
      output p2_up, p2_down, p2_left, p2_right,
      output boom1_p, boom2_p, space_p, pause_p, reset_p,
      output swapped, swap_left
   );
endinterface

// File: rtl/key_router.sv
// Turns PS/2 make codes into one-cycle player/system pulses, with a timed
// control-swap window and per-player boom cooldowns.
module key_router #(
   parameter int SWAP_LEN  = 5,
   parameter int BOOM_COOL = 10
) (
   input logic         clk,
   input logic         rstn,
   key_router_if.slave bus
);

   typedef enum logic {NORMAL, SWAPPED} swap_state_t;

   swap_state_t state;
   logic [3:0]  swap_left;
   logic [3:0]  cool1;
   logic [3:0]  cool2;
   logic [7:0]  last_code;
   logic [3:0]  mv1_q, mv2_q;
   logic        boom1_q, boom2_q, space_q, pause_q, reset_q;

   logic [7:0]  code;
   logic        accept, gate;
   logic [3:0]  pad1_mv, pad2_mv, mv1, mv2;
   logic        pad1_boom, pad2_boom;
   logic        req1, req2, grant1, grant2;
   logic        key_space, key_pause, key_reset;

   // Movement vectors are {up, down, left, right}; pad-2 arrows need the E0 prefix.
   always_comb begin
      code      = bus.key_event[7:0];
      accept    = bus.key_event[10] & ~bus.key_event[8] & (code != last_code);
      gate      = accept & bus.start;
      pad1_mv   = 4'b0000;
      pad2_mv   = 4'b0000;
      case (code)
         8'h1D:   pad1_mv = 4'b1000;
         8'h1B:   pad1_mv = 4'b0100;
         8'h1C:   pad1_mv = 4'b0010;
         8'h23:   pad1_mv = 4'b0001;
         8'h75:   pad2_mv = bus.key_event[9] ? 4'b1000 : 4'b0000;
         8'h72:   pad2_mv = bus.key_event[9] ? 4'b0100 : 4'b0000;
         8'h6B:   pad2_mv = bus.key_event[9] ? 4'b0010 : 4'b0000;
         8'h74:   pad2_mv = bus.key_event[9] ? 4'b0001 : 4'b0000;
         default: ;
      endcase
      pad1_boom = (code == 8'h16);
      pad2_boom = (code == 8'h69);
      mv1       = gate ? ((state == SWAPPED) ? pad2_mv : pad1_mv) : 4'b0000;
      mv2       = gate ? ((state == SWAPPED) ? pad1_mv : pad2_mv) : 4'b0000;
      req1      = gate & ((state == SWAPPED) ? pad2_boom : pad1_boom);
      req2      = gate & ((state == SWAPPED) ? pad1_boom : pad2_boom);
      grant1    = req1 & (cool1 == 4'd0);
      grant2    = req2 & (cool2 == 4'd0);
      key_space = accept & (code == 8'h29);
      key_pause = accept & (code == 8'h4D);
      key_reset = accept & (code == 8'h2D);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= NORMAL;
         swap_left <= 4'd0;
         cool1     <= 4'd0;
         cool2     <= 4'd0;
         last_code <= 8'h00;
         mv1_q     <= 4'b0000;
         mv2_q     <= 4'b0000;
         boom1_q   <= 1'b0;
         boom2_q   <= 1'b0;
         space_q   <= 1'b0;
         pause_q   <= 1'b0;
         reset_q   <= 1'b0;
      end else begin
         last_code <= code;
         mv1_q     <= mv1;
         mv2_q     <= mv2;
         boom1_q   <= grant1;
         boom2_q   <= grant2;
         space_q   <= key_space;
         pause_q   <= key_pause;
         reset_q   <= key_reset;

         // A grant reloads the cooldown even when a second tick lands on the same edge.
         if (key_reset) begin
            cool1 <= 4'd0;
            cool2 <= 4'd0;
         end else begin
            if (grant1)
               cool1 <= 4'(BOOM_COOL);
            else if (bus.sec_tick && bus.start && cool1 != 4'd0)
               cool1 <= cool1 - 4'd1;
            if (grant2)
               cool2 <= 4'(BOOM_COOL);
            else if (bus.sec_tick && bus.start && cool2 != 4'd0)
               cool2 <= cool2 - 4'd1;
         end

         if (key_reset) begin
            state     <= NORMAL;
            swap_left <= 4'd0;
         end else if (bus.start) begin
            case (state)
               NORMAL: begin
                  if (bus.swap_req) begin
                     state     <= SWAPPED;
                     swap_left <= 4'(SWAP_LEN);
                  end
               end
               SWAPPED: begin
                  if (bus.swap_req) begin
                     swap_left <= 4'(SWAP_LEN);
                  end else if (bus.sec_tick) begin
                     if (swap_left <= 4'd1) begin
                        state     <= NORMAL;
                        swap_left <= 4'd0;
                     end else begin
                        swap_left <= swap_left - 4'd1;
                     end
                  end
               end
               default: begin
                  state     <= NORMAL;
                  swap_left <= 4'd0;
               end
            endcase
         end
      end
   end

   assign {bus.p1_up, bus.p1_down, bus.p1_left, bus.p1_right} = mv1_q;
   assign {bus.p2_up, bus.p2_down, bus.p2_left, bus.p2_right} = mv2_q;
   assign bus.boom1_p   = boom1_q;
   assign bus.boom2_p   = boom2_q;
   assign bus.space_p   = space_q;
   assign bus.pause_p   = pause_q;
   assign bus.reset_p   = reset_q;
   assign bus.swapped   = (state == SWAPPED);
   assign bus.swap_left = swap_left;

endmodule

// File: tb/tb_key_router.sv
// Randomized and directed bench for key_router, checked against a key-table
// reference model of players, swap window and cooldowns.
module tb_key_router;

   localparam int SWAP_LEN  = 5;
   localparam int BOOM_COOL = 10;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   key_router_if bus();

   key_router #(.SWAP_LEN(SWAP_LEN), .BOOM_COOL(BOOM_COOL)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checksTotal  = 0;
   int checksPassed = 0;

   // Bit order: p1 {up,down,left,right}, p2 {up,down,left,right}, boom1, boom2, space, pause, reset.
   logic [12:0] pulses;
   assign pulses = {bus.p1_up, bus.p1_down, bus.p1_left, bus.p1_right,
                    bus.p2_up, bus.p2_down, bus.p2_left, bus.p2_right,
                    bus.boom1_p, bus.boom2_p, bus.space_p, bus.pause_p, bus.reset_p};

   int          m_cool [2];
   bit          m_sw;
   int          m_left;
   logic [7:0]  m_last;
   logic [12:0] m_pulses;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checksTotal++;
      if (observed === expected)
         checksPassed++;
      else
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
   endtask

   function automatic logic [10:0] ev(input logic [7:0] code, input logic ext);
      return {1'b1, ext, 1'b0, code};
   endfunction

   // act: -1 none, 0..3 up/down/left/right, 4 boom, 5 space, 6 pause, 7 reset.
   task automatic decodeKey(input logic [7:0] code, input logic ext, output int pad, output int act);
      pad = -1;
      act = -1;
      case (code)
         8'h1D: begin pad = 0; act = 0; end
         8'h1B: begin pad = 0; act = 1; end
         8'h1C: begin pad = 0; act = 2; end
         8'h23: begin pad = 0; act = 3; end
         8'h16: begin pad = 0; act = 4; end
         8'h75: if (ext) begin pad = 1; act = 0; end
         8'h72: if (ext) begin pad = 1; act = 1; end
         8'h6B: if (ext) begin pad = 1; act = 2; end
         8'h74: if (ext) begin pad = 1; act = 3; end
         8'h69: begin pad = 1; act = 4; end
         8'h29: act = 5;
         8'h4D: act = 6;
         8'h2D: act = 7;
         default: ;
      endcase
   endtask

   task automatic modelReset();
      m_cool[0] = 0;
      m_cool[1] = 0;
      m_sw      = 1'b0;
      m_left    = 0;
      m_last    = 8'h00;
      m_pulses  = '0;
   endtask

   task automatic modelStep(input logic [10:0] ke, input logic st, input logic tick, input logic sreq);
      logic [12:0] p;
      bit          grant [2];
      bit          rk;
      bit          acc;
      int          pad, act, player;
      p        = '0;
      grant[0] = 1'b0;
      grant[1] = 1'b0;
      rk       = 1'b0;
      acc      = ke[10] && !ke[8] && (ke[7:0] != m_last);
      decodeKey(ke[7:0], ke[9], pad, act);
      if (acc) begin
         if (act == 5) p[2] = 1'b1;
         else if (act == 6) p[1] = 1'b1;
         else if (act == 7) begin p[0] = 1'b1; rk = 1'b1; end
         else if (pad >= 0 && st) begin
            player = m_sw ? 1 - pad : pad;
            if (act < 4)
               p[12 - (player * 4 + act)] = 1'b1;
            else if (m_cool[player] == 0) begin
               p[4 - player] = 1'b1;
               grant[player] = 1'b1;
            end
         end
      end
      for (int n = 0; n < 2; n++) begin
         if (rk) m_cool[n] = 0;
         else if (grant[n]) m_cool[n] = BOOM_COOL;
         else if (st && tick && m_cool[n] > 0) m_cool[n] = m_cool[n] - 1;
      end
      if (rk) begin
         m_sw   = 1'b0;
         m_left = 0;
      end else if (st) begin
         if (sreq) begin
            m_sw   = 1'b1;
            m_left = SWAP_LEN;
         end else if (m_sw && tick) begin
            m_left = m_left - 1;
            if (m_left == 0) m_sw = 1'b0;
         end
      end
      m_last   = ke[7:0];
      m_pulses = p;
   endtask

   task automatic applyStimulus(input logic [10:0] ke, input logic st, input logic tick, input logic sreq);
      @(negedge clk);
      bus.key_event = ke;
      bus.start     = st;
      bus.sec_tick  = tick;
      bus.swap_req  = sreq;
      modelStep(ke, st, tick, sreq);
      @(posedge clk);
      #1;
      checkOutput("pulses", 32'(pulses), 32'(m_pulses));
      checkOutput("swapped", 32'(bus.swapped), 32'(m_sw));
      checkOutput("swap_left", 32'(bus.swap_left), 32'(m_left));
   endtask

   task automatic asyncReset();
      @(posedge clk);
      #3;
      bus.key_event = '0;
      rstn = 1'b0;
      #1;
      checkOutput("rst_pulses", 32'(pulses), 32'd0);
      checkOutput("rst_swapped", 32'(bus.swapped), 32'd0);
      checkOutput("rst_swap_left", 32'(bus.swap_left), 32'd0);
      modelReset();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      applyStimulus('0, 1'b1, 1'b0, 1'b0);
   endtask

   logic [7:0] codeList [15] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h16, 8'h75, 8'h6B, 8'h72,
                                 8'h74, 8'h69, 8'h29, 8'h4D, 8'h2D, 8'h00, 8'h55};

   initial begin
      logic [7:0]  rc;
      logic [10:0] rke;
      bus.key_event = '0;
      bus.start     = 1'b0;
      bus.sec_tick  = 1'b0;
      bus.swap_req  = 1'b0;
      modelReset();
      #12;
      checkOutput("init_pulses", 32'(pulses), 32'd0);
      checkOutput("init_swapped", 32'(bus.swapped), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      applyStimulus(ev(8'h1D, 1'b0), 1'b1, 1'b0, 1'b0);
      checkOutput("up_first", 32'(bus.p1_up), 32'd1);
      applyStimulus(ev(8'h1D, 1'b0), 1'b1, 1'b0, 1'b0);
      checkOutput("up_hold", 32'(bus.p1_up), 32'd0);
      applyStimulus(ev(8'h1D, 1'b0), 1'b1, 1'b0, 1'b0);
      checkOutput("up_hold2", 32'(bus.p1_up), 32'd0);

      applyStimulus('0, 1'b1, 1'b0, 1'b1);
      checkOutput("swap_on", 32'(bus.swapped), 32'd1);
      checkOutput("swap_len", 32'(bus.swap_left), 32'd5);
      applyStimulus(ev(8'h1C, 1'b0), 1'b1, 1'b0, 1'b0);
      checkOutput("crossed_left", 32'(bus.p2_left), 32'd1);
      for (int k = 1; k <= 5; k++) begin
         applyStimulus('0, 1'b1, 1'b1, 1'b0);
         checkOutput("tick_left", 32'(bus.swap_left), 32'(5 - k));
         checkOutput("tick_swapped", 32'(bus.swapped), (k < 5) ? 32'd1 : 32'd0);
      end

      applyStimulus('0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) applyStimulus('0, 1'b1, 1'b1, 1'b0);
      checkOutput("left_two", 32'(bus.swap_left), 32'd2);
      applyStimulus('0, 1'b1, 1'b1, 1'b1);
      checkOutput("reload_wins", 32'(bus.swap_left), 32'd5);
      checkOutput("reload_swapped", 32'(bus.swapped), 32'd1);

      applyStimulus(ev(8'h16, 1'b0), 1'b1, 1'b0, 1'b0);
      checkOutput("crossed_boom", 32'(bus.boom2_p), 32'd1);
      for (int k = 0; k < 3; k++) applyStimulus('0, 1'b1, 1'b1, 1'b0);
      applyStimulus(ev(8'h2D, 1'b0), 1'b1, 1'b0, 1'b0);
      checkOutput("rkey_pulse", 32'(bus.reset_p), 32'd1);
      checkOutput("rkey_swapped", 32'(bus.swapped), 32'd0);
      checkOutput("rkey_left", 32'(bus.swap_left), 32'd0);
      applyStimulus(ev(8'h69, 1'b0), 1'b1, 1'b0, 1'b0);
      checkOutput("rkey_cool2", 32'(bus.boom2_p), 32'd1);

      applyStimulus(ev(8'h16, 1'b0), 1'b1, 1'b0, 1'b0);
      checkOutput("boom1_grant", 32'(bus.boom1_p), 32'd1);
      applyStimulus(ev(8'h00, 1'b0), 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) applyStimulus('0, 1'b1, 1'b1, 1'b0);
      applyStimulus(ev(8'h16, 1'b0), 1'b1, 1'b0, 1'b0);
      checkOutput("boom1_denied", 32'(bus.boom1_p), 32'd0);
      applyStimulus(ev(8'h00, 1'b0), 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) applyStimulus('0, 1'b1, 1'b1, 1'b0);
      applyStimulus(ev(8'h16, 1'b0), 1'b1, 1'b0, 1'b0);
      checkOutput("boom1_again", 32'(bus.boom1_p), 32'd1);

      applyStimulus(ev(8'h75, 1'b0), 1'b1, 1'b0, 1'b0);
      checkOutput("arrow_noext", 32'(pulses), 32'd0);
      applyStimulus(ev(8'h23, 1'b0), 1'b0, 1'b0, 1'b0);
      checkOutput("stopped_move", 32'(pulses), 32'd0);
      applyStimulus(ev(8'h29, 1'b0), 1'b0, 1'b0, 1'b0);
      checkOutput("stopped_space", 32'(bus.space_p), 32'd1);

      applyStimulus('0, 1'b1, 1'b0, 1'b1);
      applyStimulus('0, 1'b1, 1'b1, 1'b0);
      asyncReset();

      for (int i = 0; i < 3000; i++) begin
         rc = codeList[$urandom_range(0, 14)];
         if (rc == 8'h2D && ($urandom % 4) != 0) rc = 8'h00;
         rke = {1'($urandom % 8 != 0), 1'($urandom % 2), 1'($urandom % 6 == 0), rc};
         applyStimulus(rke, 1'($urandom % 10 != 0), 1'($urandom % 4 == 0), 1'($urandom % 25 == 0));
         if (i % 1000 == 500) asyncReset();
      end

      $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
